// File: rtl/sram_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : sram_mem_stage
// Brief   : LDR/STR memory stage; 32-bit access to 16-bit SRAM in two halfword phases.
// Revision: 1.0 - initial release
// ============================================================================
module sram_mem_stage #(
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        ALU_Res,
   input  logic [31:0]        ST_val,
   output logic               ready,
   output logic [31:0]        read_data,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic [15:0]        SRAM_DQ_OUT,
   output logic               SRAM_DQ_OE,
   input  logic [15:0]        SRAM_DQ_IN
);

   localparam int            C_CW   = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [C_CW-1:0] C_LAST = C_CW'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [C_CW-1:0]     r_cnt;
   logic                r_is_write;
   logic [SRAM_AW-2:0]  r_word_idx;
   logic [31:0]         r_data;
   logic [15:0]         r_rd_lo;
   logic [31:0]         r_read_data;

   logic                w_req;
   logic                w_last;
   logic [SRAM_AW-2:0]  w_word_idx;

   assign w_req      = MEM_W_EN | MEM_R_EN;
   assign w_last     = (r_cnt == C_LAST);
   // Word index relative to BASE_ADDR with 32-bit wrap; byte offset bits dropped.
   assign w_word_idx = (SRAM_AW-1)'((ALU_Res - 32'(BASE_ADDR)) >> 2);
   assign read_data  = r_read_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_LOW || r_state == S_HIGH) && !w_last)
            r_cnt <= r_cnt + 1'b1;
         else
            r_cnt <= '0;
      end
   end

   always_comb begin
      w_next      = r_state;
      ready       = 1'b0;
      SRAM_ADDR   = '0;
      SRAM_WE_N   = 1'b1;
      SRAM_DQ_OUT = '0;
      SRAM_DQ_OE  = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = ~w_req;
            if (w_req)
               w_next = S_LOW;
         end
         S_LOW, S_HIGH: begin
            SRAM_ADDR = {r_word_idx, (r_state == S_HIGH)};
            if (r_is_write) begin
               SRAM_DQ_OE  = 1'b1;
               SRAM_DQ_OUT = (r_state == S_HIGH) ? r_data[31:16] : r_data[15:0];
               // Release WE_N on the last cycle so the SRAM latches on its rising edge.
               SRAM_WE_N   = w_last;
            end
            if (w_last)
               w_next = (r_state == S_LOW) ? S_HIGH : S_DONE;
         end
         S_DONE: begin
            ready  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_write  <= 1'b0;
         r_word_idx  <= '0;
         r_data      <= '0;
         r_rd_lo     <= '0;
         r_read_data <= '0;
      end else begin
         if (r_state == S_IDLE && w_req) begin
            r_is_write <= MEM_W_EN;
            r_word_idx <= w_word_idx;
            r_data     <= ST_val;
         end
         if (r_state == S_LOW && w_last && !r_is_write)
            r_rd_lo <= SRAM_DQ_IN;
         if (r_state == S_HIGH && w_last && !r_is_write)
            r_read_data <= {SRAM_DQ_IN, r_rd_lo};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_mem_stage
// Brief   : Directed bench with a behavioural SRAM that latches on WE_N rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_mem_stage;

   localparam int C_AW = 18;

   logic              clk = 1'b0;
   logic              rst;
   logic              MEM_R_EN, MEM_W_EN;
   logic [31:0]       ALU_Res, ST_val;
   logic              ready;
   logic [31:0]       read_data;
   logic [C_AW-1:0]   SRAM_ADDR;
   logic              SRAM_WE_N;
   logic [15:0]       SRAM_DQ_OUT;
   logic              SRAM_DQ_OE;
   logic [15:0]       SRAM_DQ_IN;

   logic [15:0]       r_mem [0:63];
   int                n_checks = 0;
   int                n_errors = 0;
   logic [31:0]       r_exp_rd;

   always #5 clk = ~clk;

   sram_mem_stage #(.BASE_ADDR(1024), .SRAM_AW(C_AW), .WAIT_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .MEM_R_EN    (MEM_R_EN),
      .MEM_W_EN    (MEM_W_EN),
      .ALU_Res     (ALU_Res),
      .ST_val      (ST_val),
      .ready       (ready),
      .read_data   (read_data),
      .SRAM_ADDR   (SRAM_ADDR),
      .SRAM_WE_N   (SRAM_WE_N),
      .SRAM_DQ_OUT (SRAM_DQ_OUT),
      .SRAM_DQ_OE  (SRAM_DQ_OE),
      .SRAM_DQ_IN  (SRAM_DQ_IN)
   );

   always @(posedge SRAM_WE_N)
      if (SRAM_DQ_OE === 1'b1)
         r_mem[SRAM_ADDR[5:0]] = SRAM_DQ_OUT;

   assign SRAM_DQ_IN = r_mem[SRAM_ADDR[5:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One access from its IDLE cycle to its DONE cycle; returns positioned in DONE.
   task automatic access(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] data, input logic hold,
                         input int exp_we_low, input int exp_oe);
      int n_low, n_we, n_oe;
      n_low = 0; n_we = 0; n_oe = 0;
      @(negedge clk);
      MEM_W_EN = we; MEM_R_EN = re; ALU_Res = addr; ST_val = data;
      #1;
      while (ready !== 1'b1 && n_low < 50) begin
         if (SRAM_WE_N === 1'b0) n_we++;
         if (SRAM_DQ_OE === 1'b1) n_oe++;
         n_low++;
         @(negedge clk);
         if (!hold) begin MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; end
      end
      check("ready_low_cycles", 32'(n_low), 32'd7);
      check("ready_done", {31'd0, ready}, 32'd1);
      check("we_low_cycles", 32'(n_we), 32'(exp_we_low));
      check("oe_cycles", 32'(n_oe), 32'(exp_oe));
      check("read_data", read_data, r_exp_rd);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) r_mem[i] = 16'h0000;
      rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_Res = '0; ST_val = '0;
      r_exp_rd = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_read_data", read_data, 32'h0);
      check("rst_addr", 32'(SRAM_ADDR), 32'h0);
      check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("rst_dq_out", {16'd0, SRAM_DQ_OUT}, 32'h0);
      check("rst_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
      rst = 1'b0;

      access(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1'b0, 4, 6);
      check("mem0", {16'd0, r_mem[0]}, 32'h5678);
      check("mem1", {16'd0, r_mem[1]}, 32'h1234);

      r_exp_rd = 32'h1234_5678;
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 0, 0);

      access(1'b1, 1'b0, 32'd1035, 32'hDEAD_BEEF, 1'b0, 4, 6);
      check("mem4", {16'd0, r_mem[4]}, 32'hBEEF);
      check("mem5", {16'd0, r_mem[5]}, 32'hDEAD);

      access(1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F, 1'b0, 4, 6);
      check("mem2", {16'd0, r_mem[2]}, 32'h0F0F);
      check("mem3", {16'd0, r_mem[3]}, 32'hA5A5);

      r_exp_rd = 32'hDEAD_BEEF;
      access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 0, 0);

      // Enables held through DONE: the next access must start immediately.
      access(1'b1, 1'b0, 32'd1048, 32'h1111_2222, 1'b1, 4, 6);
      access(1'b1, 1'b0, 32'd1048, 32'h1111_2222, 1'b0, 4, 6);
      check("mem12", {16'd0, r_mem[12]}, 32'h2222);
      check("mem13", {16'd0, r_mem[13]}, 32'h1111);

      // Reset during the HIGH phase of a store.
      @(negedge clk);
      MEM_W_EN = 1'b1; ALU_Res = 32'd1040; ST_val = 32'hCAFE_F00D;
      repeat (4) @(negedge clk);
      check("mid_high_addr", 32'(SRAM_ADDR), 32'd9);
      check("mid_high_we_n", {31'd0, SRAM_WE_N}, 32'd0);
      rst = 1'b1; MEM_W_EN = 1'b0;
      @(negedge clk);
      check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("abort_dq_oe", {31'd0, SRAM_DQ_OE}, 32'd0);
      check("abort_read_data", read_data, 32'h0);
      check("abort_ready_idle", {31'd0, ready}, 32'd1);
      MEM_R_EN = 1'b1;
      #1;
      check("abort_ready_req", {31'd0, ready}, 32'd0);
      MEM_R_EN = 1'b0;
      rst = 1'b0;

      r_exp_rd = 32'h1234_5678;
      access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
